// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the parameterised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_DIS   = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam int          DEFAULT_MAX_LEN = 8;
  localparam int          DEFAULT_CNT_W   = 8;
  localparam logic [31:0] DEFAULT_PATTERN = 32'h0000_0006;
  localparam int          DEFAULT_LEN     = 4;
  localparam bit          DEFAULT_OVERLAP = 1'b1;

  function automatic logic len_legal(input int len, input int max_len);
    return (len > 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational compare of the low len bits of history against pattern.
module seq_match_cmp #(
  parameter int MAX_LEN = 8
) (
  input  logic [MAX_LEN-1:0]             history,
  input  logic [MAX_LEN-1:0]             pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  output logic                           eq
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] mask;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (len > LW'(gi));
    end
  endgenerate

  assign eq = ~|((history ^ pattern) & mask);

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int                 CNT_W       = DEFAULT_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEFAULT_PATTERN[MAX_LEN-1:0],
  parameter int                 DEF_LEN     = DEFAULT_LEN,
  parameter bit                 DEF_OVERLAP = DEFAULT_OVERLAP
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           x,
  input  logic                           x_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           z,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_err
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [LW-1:0]      len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic [MAX_LEN-1:0] history_reg, history_next;
  logic [LW-1:0]      fill_reg, fill_next;
  logic               z_reg, z_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [MAX_LEN-1:0] shifted;
  logic [LW-1:0]      fill_adv;
  logic               cmp_eq;
  logic               match;
  logic               armed;

  assign shifted  = {history_reg[MAX_LEN-2:0], x};
  assign fill_adv = (fill_reg < len_reg) ? fill_reg + 1'b1 : fill_reg;

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .history (shifted),
    .pattern (pattern_reg),
    .len     (len_reg),
    .eq      (cmp_eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg <= DEF_PATTERN;
      len_reg     <= LW'(DEF_LEN);
      overlap_reg <= DEF_OVERLAP;
      history_reg <= '0;
      fill_reg    <= '0;
      z_reg       <= 1'b0;
      count_reg   <= '0;
    end else begin
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      history_reg <= history_next;
      fill_reg    <= fill_next;
      z_reg       <= z_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    history_next = history_reg;
    fill_next    = fill_reg;
    match        = 1'b0;

    if (cfg_load) begin
      // The x bit of a load cycle is dropped; the new pattern starts from empty history.
      pattern_next = cfg_pattern;
      len_next     = cfg_len;
      overlap_next = cfg_overlap;
      history_next = '0;
      fill_next    = '0;
      if (!len_legal(int'(cfg_len), MAX_LEN)) begin
        state_next = ST_DIS;
      end else if (cfg_len == LW'(1)) begin
        state_next = ST_ARMED;
      end else begin
        state_next = ST_FILL;
      end
    end else if (x_valid && (state_reg != ST_DIS)) begin
      history_next = shifted;
      match        = armed && cmp_eq;
      fill_next    = (match && !overlap_reg) ? '0 : fill_adv;
      state_next   = (fill_next >= len_reg - 1'b1) ? ST_ARMED : ST_FILL;
    end

    z_next = match;

    // A clear in the same cycle as a match wins; the match is not counted.
    count_next = count_reg;
    if (cnt_clr) begin
      count_next = '0;
    end else if (match && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_comb begin
    cfg_err     = (state_reg == ST_DIS);
    armed       = (state_reg == ST_ARMED);
    z           = z_reg;
    match_count = count_reg;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic               clk;
  logic               reset;
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: accepted bits since the last load/reset (or since the last
  // match in non-overlap mode), checked against the pattern read first-bit-first.
  bit       mq[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ov;
  bit       m_err;
  int       m_cnt;
  bit       m_z;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit v, input bit b, input bit ld, input bit clr, input bit rst,
                      input bit [7:0] lp, input bit [3:0] ll, input bit lo);
    bit hit;
    reset       = rst;
    x_valid     = v;
    x           = b;
    cfg_load    = ld;
    cnt_clr     = clr;
    cfg_pattern = lp;
    cfg_len     = ll;
    cfg_overlap = lo;
    hit = 1'b0;
    if (rst) begin
      mq.delete();
      m_pat = 8'h06; m_len = 4; m_ov = 1'b1; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (ld) begin
        m_pat = lp; m_len = int'(ll); m_ov = lo;
        m_err = (ll == 0) || (int'(ll) > MAX_LEN);
        mq.delete();
      end else if (v && !m_err) begin
        mq.push_back(b);
        if (mq.size() > MAX_LEN) void'(mq.pop_front());
        if (mq.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (mq[mq.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
        end
        if (hit && !m_ov) mq.delete();
      end
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
    m_z = hit;
    @(negedge clk);
    reset = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 1, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("FAIL reset_z: got %b required 0", z); end
    tests_run++;
    if (match_count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d required 0", match_count); end
    tests_run++;
    if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_err: got %b required 0", cfg_err); end
  endtask

  task automatic test_default_overlap();
    logic [6:0] s;
    int pulses;
    s = 7'b0110110;
    pulses = 0;
    step(0, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(1, s[i], 0, 0, 0, 8'h00, 4'd0, 1'b0);
      tests_run++;
      if (z !== ((i == 3) || (i == 0))) begin
        tests_failed++;
        $display("FAIL default_z bit%0d: got %b required %b", 7 - i, z, (i == 3) || (i == 0));
      end
      if (z === 1'b1) pulses++;
    end
    tests_run++;
    if (match_count !== 2'd2) begin tests_failed++; $display("FAIL default_count: got %0d required 2", match_count); end
    tests_run++;
    if (pulses != 2) begin tests_failed++; $display("FAIL default_pulses: got %0d required 2", pulses); end
  endtask

  task automatic test_pattern_101(input bit ov);
    logic [4:0] s;
    s = 5'b10101;
    step(0, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    step(1, 1, 1, 0, 0, 8'b0000_0101, 4'd3, ov);
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("FAIL p101_load_z ov=%0d: got %b required 0", ov, z); end
    for (int i = 4; i >= 0; i--) begin
      step(1, s[i], 0, 0, 0, 8'h00, 4'd0, 1'b0);
      tests_run++;
      if (z !== ((i == 2) || (ov && i == 0))) begin
        tests_failed++;
        $display("FAIL p101_z ov=%0d bit%0d: got %b required %b", ov, 5 - i, z, (i == 2) || (ov && i == 0));
      end
    end
    tests_run++;
    if (int'(match_count) != (ov ? 2 : 1)) begin
      tests_failed++;
      $display("FAIL p101_count ov=%0d: got %0d required %0d", ov, match_count, ov ? 2 : 1);
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] s;
    s = 4'b0110;
    step(0, 0, 1, 0, 0, 8'b0000_0110, 4'd0, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b required 1", cfg_err); end
    for (int i = 3; i >= 0; i--) begin
      step(1, s[i], 0, 0, 0, 8'h00, 4'd0, 1'b0);
      tests_run++;
      if (z !== 1'b0) begin tests_failed++; $display("FAIL err_no_z bit%0d: got %b required 0", 4 - i, z); end
    end
    step(0, 0, 1, 0, 0, 8'b0000_0110, 4'd9, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL err_len9: got %b required 1", cfg_err); end
    step(0, 0, 1, 0, 0, 8'b0000_0110, 4'd4, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b required 0", cfg_err); end
    for (int i = 3; i >= 0; i--) begin
      step(1, s[i], 0, 0, 0, 8'h00, 4'd0, 1'b0);
      tests_run++;
      if (z !== (i == 0)) begin tests_failed++; $display("FAIL err_resume bit%0d: got %b required %b", 4 - i, z, i == 0); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s;
    s = 16'b0110_1101_1011_0110;
    step(0, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    for (int i = 15; i >= 0; i--) step(1, s[i], 0, 0, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (match_count !== 2'd3) begin tests_failed++; $display("FAIL sat_hold: got %0d required 3", match_count); end
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 0, 0, 1, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b1) begin tests_failed++; $display("FAIL clr_match_z: got %b required 1", z); end
    tests_run++;
    if (match_count !== 2'd0) begin tests_failed++; $display("FAIL clr_match_count: got %0d required 0", match_count); end
  endtask

  task automatic test_reset_mid_and_gaps();
    step(0, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    step(1, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    step(1, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_z: got %b required 0", z); end
    step(0, 0, 0, 0, 1, 8'h00, 4'd0, 1'b0);
    step(1, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(0, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(0, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(0, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(1, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    step(0, 1, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("FAIL gap_early_z: got %b required 0", z); end
    step(1, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b1) begin tests_failed++; $display("FAIL gap_final_z: got %b required 1", z); end
    step(0, 0, 0, 0, 0, 8'h00, 4'd0, 1'b0);
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("FAIL gap_pulse_end: got %b required 0", z); end
  endtask

  task automatic test_len1();
    step(0, 0, 1, 0, 0, 8'b0000_0001, 4'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1, i[0], 0, 0, 0, 8'h00, 4'd0, 1'b0);
      tests_run++;
      if (z !== m_z) begin tests_failed++; $display("FAIL len1_z step%0d: got %b required %b", i, z, m_z); end
    end
  endtask

  task automatic test_random();
    bit rst, ld, clr, v, b, lo;
    bit [7:0] lp;
    bit [3:0] ll;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      lo  = 1'($urandom);
      lp  = 8'($urandom);
      ll  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(v, b, ld, clr, rst, lp, ll, lo);
      tests_run++;
      if (z !== m_z || int'(match_count) != m_cnt || cfg_err !== m_err) begin
        tests_failed++;
        $display("FAIL random_step%0d: got z=%b cnt=%0d err=%b required z=%b cnt=%0d err=%b",
                 n, z, match_count, cfg_err, m_z, m_cnt, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_default_overlap();
    test_pattern_101(1'b0);
    test_pattern_101(1'b1);
    test_cfg_err();
    test_saturation();
    test_reset_mid_and_gaps();
    test_len1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, width of match_count.
REQ-003 Parameter DEF_PATTERN, default 8'b0000_0110, pattern loaded at reset (LSB-aligned).
REQ-004 Parameter DEF_LEN, default 4, pattern length loaded at reset.
REQ-005 Parameter DEF_OVERLAP, default 1, overlap mode loaded at reset.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 x  input  1  serial data bit.
REQ-009 x_valid  input  1  x is sampled only on cycles where x_valid=1.
REQ-010 cfg_load  input  1  one-cycle strobe capturing cfg_pattern, cfg_len, cfg_overlap.
REQ-011 cfg_pattern  input  MAX_LEN  pattern, LSB-aligned; bit cfg_len-1 is the first bit expected.
REQ-012 cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-013 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 cnt_clr  input  1  synchronous clear of match_count.
REQ-015 z  output  1  registered Moore detect flag.
REQ-016 match_count  output  CNT_W  saturating count of detections.
REQ-017 cfg_err  output  1  active configuration is illegal; detector disabled.

Function
REQ-018 Block SHALL keep a MAX_LEN-bit history register; on each x_valid cycle history shifts left with x entering bit 0.
REQ-019 Block SHALL keep a fill counter, incremented per accepted bit, saturating at the active length L.
REQ-020 FSM states SHALL be ST_DIS (cfg_err=1), ST_FILL (fill < L-1), ST_ARMED (fill >= L-1).
REQ-021 A match SHALL occur on an accepted bit when state is ST_ARMED and the low L bits of the shifted history equal pattern[L-1:0].
REQ-022 z SHALL be 1 exactly in the cycle after the matching bit is accepted and 0 otherwise (one-cycle latency, one-cycle pulse).
REQ-023 Overlap mode SHALL keep history and fill after a match; non-overlap mode SHALL reset fill to 0 after a match (next match needs L fresh bits).
REQ-024 Cycles with x_valid=0 SHALL not change history, fill, or state; z SHALL be 0 in the following cycle.
REQ-025 match_count SHALL increment by 1 per match and hold at 2^CNT_W-1 when saturated.
REQ-026 cnt_clr SHALL zero match_count next cycle; a simultaneous match SHALL be discarded from the count (clear wins), z still pulses.
REQ-027 cfg_load SHALL capture configuration, clear history and fill, and force z=0 next cycle; the x bit of that cycle SHALL be discarded.
REQ-028 cfg_len=0 or cfg_len>MAX_LEN SHALL set cfg_err=1 and enter ST_DIS; no matches until a legal cfg_load.
REQ-029 cfg_len=1 SHALL enter ST_ARMED directly and match on every accepted bit equal to pattern[0].
REQ-030 match_count SHALL be unaffected by cfg_load.

Reset
REQ-031 reset SHALL set z=0, match_count=0, cfg_err=0, history=0, fill=0, pattern=DEF_PATTERN, L=DEF_LEN, overlap=DEF_OVERLAP, state ST_FILL.
REQ-032 reset SHALL take priority over cfg_load, cnt_clr and x_valid in the same cycle; mid-sequence reset discards partial matches.

Structure
REQ-033 Package seq_det_pkg SHALL hold the state enum (ST_DIS, ST_FILL, ST_ARMED) and default constants.
REQ-034 Masked compare of history against pattern under length L SHALL be a sub-module seq_match_cmp (combinational, MAX_LEN parameter).

Verification
REQ-035 Reset defaults, overlap=1, stream 0110110 valid every cycle -> z pulses after 4th and 7th bits; match_count=2.
REQ-036 cfg_load pattern=3'b101, len=3, overlap=0; stream 10101 -> one z pulse after bit 3 only; match_count=1.
REQ-037 Same pattern, overlap=1, stream 10101 -> z pulses after bits 3 and 5; match_count=2.
REQ-038 cfg_load len=0 -> cfg_err=1, stream 0110 gives no z; then load len=4 pattern 0110 -> cfg_err=0, detection resumes.
REQ-039 CNT_W=2, 5 matches -> match_count holds 3; cnt_clr coincident with 6th match -> match_count=0, z=1.
REQ-040 Reset asserted after bits 011 of 0110, then bit 0 -> no z; x_valid gaps inside 0_1_1_0 -> z after final valid bit.
